// File: rtl/pac_pkg.sv
// Shared types and defaults for the Pac-Man life/death sequencing logic.
package pac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESPAWN,
        ST_PLAY,
        ST_DYING,
        ST_OVER
    } pac_state_t;

    localparam int LIVES_W = 3;
    localparam int DEATH_W = 7;
    localparam int INV_W   = 8;

    localparam int LIVES_INIT_DEF    = 3;
    localparam int DEATH_FRAMES_DEF  = 60;
    localparam int INVULN_FRAMES_DEF = 120;

endpackage

// File: rtl/pac_frame_counter.sv
// Loadable frame counter: steps once per enabled tick, holds at its terminal count.
module pac_frame_counter #(
    parameter int W      = 8,
    parameter int TC_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic         up,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         tc
);

    // Up-counters stop at TC_VAL, down-counters stop at zero.
    assign tc = up ? (count == W'(TC_VAL)) : (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !tc) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/pac_life_manager.sv
// Life/death sequencer: freezes play on a collision, runs the death animation,
// decrements lives, respawns with an invulnerability window, and flags game over.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | after reset, frozen, waiting for start
// ST_RESPAWN | one cycle, respawn pulse, invulnerability window loaded
// ST_PLAY    | movement enabled, crash honoured once inv_cnt has drained
// ST_DYING   | frozen, death animation advancing on frame ticks
// ST_OVER    | no lives left, frozen, waiting for start
module pac_life_manager
    import pac_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               crash,
    input  logic               frame_tick,
    input  logic               start,
    output logic [LIVES_W-1:0] lives,
    output logic               freeze,
    output logic               respawn,
    output logic               invuln,
    output logic               dying,
    output logic [DEATH_W-1:0] death_frame,
    output logic               game_over
);

    pac_state_t         state;
    logic [INV_W-1:0]   inv_cnt;
    logic               inv_zero;
    logic               death_last;
    logic               hit;

    // Crash is judged against the pre-tick inv_cnt, so a tick that drains the
    // window does not also let the same-cycle crash through.
    assign hit    = (state == ST_PLAY) && crash && inv_zero;
    assign invuln = (state == ST_PLAY) && (inv_cnt != '0);

    pac_frame_counter #(
        .W      (INV_W),
        .TC_VAL (0)
    ) u_inv_cnt (
        .clk      (clk),
        .rst      (rst),
        .tick     ((state == ST_PLAY) && frame_tick),
        .load     (state == ST_RESPAWN),
        .up       (1'b0),
        .load_val (INV_W'(INVULN_FRAMES)),
        .count    (inv_cnt),
        .tc       (inv_zero)
    );

    pac_frame_counter #(
        .W      (DEATH_W),
        .TC_VAL (DEATH_FRAMES - 1)
    ) u_death_cnt (
        .clk      (clk),
        .rst      (rst),
        .tick     ((state == ST_DYING) && frame_tick),
        .load     (hit),
        .up       (1'b1),
        .load_val ('0),
        .count    (death_frame),
        .tc       (death_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lives     <= LIVES_W'(LIVES_INIT);
            freeze    <= 1'b1;
            respawn   <= 1'b0;
            dying     <= 1'b0;
            game_over <= 1'b0;
        end else begin
            respawn <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state     <= ST_RESPAWN;
                        lives     <= LIVES_W'(LIVES_INIT);
                        respawn   <= 1'b1;
                        freeze    <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                ST_RESPAWN: begin
                    state  <= ST_PLAY;
                    freeze <= 1'b0;
                end
                ST_PLAY: begin
                    if (hit) begin
                        state  <= ST_DYING;
                        lives  <= lives - 1'b1;
                        freeze <= 1'b1;
                        dying  <= 1'b1;
                    end
                end
                ST_DYING: begin
                    if (frame_tick && death_last) begin
                        dying <= 1'b0;
                        // lives was already decremented on DYING entry
                        if (lives == '0) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state   <= ST_RESPAWN;
                            respawn <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    freeze <= 1'b1;
                    dying  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pac_life_manager.md
# pac_life_manager

Sequential responder on the consumer side of the ghost-collision signal. It takes the level `crash` flag from the collision checker and the per-frame tick from the VGA timing. It runs the life/death cycle: freeze the game, play the death animation, decrement lives, respawn with an invulnerability window, and declare game over. It sits between the collision checkers and the Pac/ghost movement controllers, which obey `freeze` and `respawn`.

## Interface
Parameters:
- `LIVES_INIT`, 3: lives loaded at game start; range 1..7.
- `DEATH_FRAMES`, 60: frames the death animation lasts; range 1..127.
- `INVULN_FRAMES`, 120: frames after respawn during which `crash` is ignored; range 0..255.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous reset, active-high.
- `crash`, in, 1: level; 1 while Pac overlaps any ghost.
- `frame_tick`, in, 1: single-cycle pulse, once per frame.
- `start`, in, 1: single-cycle pulse, begins a new game.
- `lives`, out, 3: remaining lives.
- `freeze`, out, 1: 1 means movement controllers hold positions.
- `respawn`, out, 1: single-cycle pulse; controllers reload spawn positions.
- `invuln`, out, 1: 1 while the invulnerability window is active (sprite blink).
- `dying`, out, 1: 1 during the death animation.
- `death_frame`, out, 7: death animation frame index, 0..DEATH_FRAMES-1.
- `game_over`, out, 1: 1 in the OVER state.

## Operation
States: IDLE, RESPAWN, PLAY, DYING, OVER.

Reset values:
- state = IDLE, lives = LIVES_INIT, freeze = 1, respawn = 0.
- invuln = 0, dying = 0, death_frame = 0, game_over = 0.
- Internal invulnerability counter `inv_cnt` = 0.

Transitions:
- **IDLE:** freeze = 1. On `start`: lives <= LIVES_INIT, go to RESPAWN.
- **RESPAWN:** lasts exactly 1 cycle. respawn = 1, freeze = 1, inv_cnt <= INVULN_FRAMES. Then go to PLAY.
- **PLAY:** freeze = 0.
  - `frame_tick` with inv_cnt != 0: decrement inv_cnt.
  - `crash` = 1 with inv_cnt == 0: lives <= lives-1, death_frame <= 0, go to DYING.
  - `crash` with inv_cnt != 0 is ignored.
- **DYING:** freeze = 1, dying = 1. Each `frame_tick` increments death_frame. A `frame_tick` while death_frame == DEATH_FRAMES-1 exits: to OVER if lives == 0, else to RESPAWN.
- **OVER:** game_over = 1, freeze = 1, lives = 0. On `start`: lives <= LIVES_INIT, go to RESPAWN.

Outputs and arithmetic:
- invuln = (state == PLAY) && (inv_cnt != 0).
- All outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.
- lives never underflows. Entering DYING always requires lives >= 1, because OVER is reached before lives can go below 0.
- death_frame saturates at DEATH_FRAMES-1 and is cleared on DYING entry.

Boundary rules:
- `crash` is level-sensitive. If it is still high when inv_cnt reaches 0 in PLAY, death triggers on that cycle.
- `crash` and `frame_tick` in the same PLAY cycle with inv_cnt == 1: crash ignored (it uses the pre-decrement value); inv_cnt becomes 0.
- `crash` and `frame_tick` in the same cycle with inv_cnt == 0: go to DYING. That tick is not counted.
- `start` is ignored in RESPAWN, PLAY and DYING.
- INVULN_FRAMES = 0: crash is vulnerable from the first PLAY cycle.
- `rst` mid-DYING or mid-PLAY: immediate return to reset values, no respawn pulse.

## Timing
- `start` at cycle N: RESPAWN (respawn = 1) at N+1, PLAY with freeze = 0 at N+2.
- Qualifying `crash` at cycle N: freeze = 1, dying = 1 and the decremented lives are visible at N+1.
- Death duration is exactly DEATH_FRAMES frame_ticks after DYING entry. The respawn pulse is 1 cycle after the final tick.
- Invulnerability lasts INVULN_FRAMES frame_ticks after entering PLAY.

## Structure
- Shared package `pac_pkg` holds:
  - The state enum (IDLE, RESPAWN, PLAY, DYING, OVER).
  - Defaults LIVES_INIT_DEF, DEATH_FRAMES_DEF, INVULN_FRAMES_DEF.
  - The lives width constant.
- One sub-module, `pac_frame_counter`: a loadable counter enabled by frame_tick, with load, up/down and terminal-count flag. It is instantiated twice, for death_frame (up) and inv_cnt (down).

## Test plan
- Reset, then `start` -> respawn pulse 1 cycle later; freeze = 0 two cycles after start; lives = 3; invuln = 1.
- `crash` held high from the first PLAY cycle with INVULN_FRAMES = 4 -> no death until the 4th frame_tick. Next cycle: dying = 1, lives = 2.
- DEATH_FRAMES = 3 -> death_frame steps 0, 1, 2 on ticks. The 3rd tick gives RESPAWN; respawn pulse 1 cycle, then PLAY.
- Three deaths from LIVES_INIT = 3 -> after the third death animation, game_over = 1, lives = 0, no respawn pulse. `start` -> lives = 3 and a respawn pulse.
- `crash` and `frame_tick` in the same cycle with inv_cnt = 1 -> no death; inv_cnt = 0. `crash` on the following cycle -> dying = 1.
- `rst` asserted mid-DYING (death_frame = 2) -> all outputs at reset values asynchronously; `start` is required to resume.
